// File: rtl/lsensor_pkg.sv
// Shared definitions for the line-sensor sequencer: FSM states and the
// default config-RAM word addresses of the G11620 register map.
package lsensor_pkg;

  localparam int         LS_CNT_W       = 32;
  localparam logic [7:0] LS_INTEG_ADDR  = 8'd1;
  localparam logic [7:0] LS_FRAMES_ADDR = 8'd2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RD_INTEG  = 3'd1,
    S_RD_FRAMES = 3'd2,
    S_INTEG     = 3'd3,
    S_WAIT_SP   = 3'd4,
    S_DATA      = 3'd5,
    S_BLANK     = 3'd6,
    S_DONE      = 3'd7
  } state_e;

endpackage

// File: rtl/lsensor_pix_capture.sv
// DATA-phase pixel capture: runs the in-line pixel index and registers the
// outgoing pixel beat one cycle after the ADC sample.
module lsensor_pix_capture #(
  parameter int PIX_NUM = 512,
  parameter int ADC_W   = 12,
  localparam int IDX_W  = $clog2(PIX_NUM)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             active,
  input  logic [ADC_W-1:0] adc_data,
  output logic             line_last,
  output logic             pix_valid,
  output logic [ADC_W-1:0] pix_data,
  output logic [IDX_W-1:0] pix_idx,
  output logic             pix_last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIX_NUM - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  logic [IDX_W-1:0] idx_r;

  assign line_last = (idx_r == LAST_IDX);

  // Index counter and registered pixel beat; data/idx hold between beats.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_r     <= {IDX_W{1'b0}};
      pix_valid <= 1'b0;
      pix_data  <= {ADC_W{1'b0}};
      pix_idx   <= {IDX_W{1'b0}};
      pix_last  <= 1'b0;
    end else begin
      if (start) begin
        idx_r <= {IDX_W{1'b0}};
      end else if (active) begin
        idx_r <= idx_r + IDX_ONE;
      end else begin
        idx_r <= idx_r;
      end
      pix_valid <= active;
      pix_last  <= active & line_last;
      if (active) begin
        pix_data <= adc_data;
        pix_idx  <= idx_r;
      end
    end
  end

endmodule

// File: rtl/lsensor_ctrl.sv
// Line-sensor acquisition sequencer: reads integration time and frame count
// from config RAM, then runs INTEG / WAIT_SP / DATA / BLANK per line.
module lsensor_ctrl
  import lsensor_pkg::*;
#(
  parameter int         PIX_NUM     = 512,
  parameter int         ADC_W       = 12,
  parameter int         CNT_W       = LS_CNT_W,
  parameter int         BLANK_CYC   = 24,
  parameter int         SP_TIMEOUT  = 4096,
  parameter logic [7:0] INTEG_ADDR  = LS_INTEG_ADDR,
  parameter logic [7:0] FRAMES_ADDR = LS_FRAMES_ADDR
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       sensor_clk_o,
  output logic                       reset_o,
  input  logic                       ad_sp,
  input  logic [ADC_W-1:0]           adc_data,
  input  logic                       start_in,
  input  logic                       soft_reset_in,
  output logic                       cfg_ram_rd_o,
  output logic [7:0]                 cfg_ram_addr_o,
  input  logic [31:0]                cfg_ram_din,
  output logic                       pix_valid_o,
  output logic [ADC_W-1:0]           pix_data_o,
  output logic [$clog2(PIX_NUM)-1:0] pix_idx_o,
  output logic                       pix_last_o,
  output logic [15:0]                frame_cnt_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_timeout_o
);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] SP_LAST    = CNT_W'(SP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  state_e           state_r;
  logic             start_r;
  logic [CNT_W-1:0] clk_cnt_r;
  logic [CNT_W-1:0] integ_r;
  logic [15:0]      frames_r;

  logic start_s;
  logic abort_s;
  logic cap_start_s;
  logic cap_active_s;
  logic line_last_s;
  logic more_s;

  assign sensor_clk_o = ~clk;
  assign start_s      = start_in & ~start_r;
  assign abort_s      = soft_reset_in & (state_r != S_IDLE);
  assign cap_start_s  = (state_r == S_WAIT_SP) & ad_sp & ~soft_reset_in;
  assign cap_active_s = (state_r == S_DATA) & ~soft_reset_in;
  // frames == 0 selects continuous acquisition.
  assign more_s = (frames_r == 16'd0) ||
                  (({1'b0, frame_cnt_o} + 17'd1) < {1'b0, frames_r});

  lsensor_pix_capture #(
    .PIX_NUM (PIX_NUM),
    .ADC_W   (ADC_W)
  ) u_pix_capture (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (cap_start_s),
    .active    (cap_active_s),
    .adc_data  (adc_data),
    .line_last (line_last_s),
    .pix_valid (pix_valid_o),
    .pix_data  (pix_data_o),
    .pix_idx   (pix_idx_o),
    .pix_last  (pix_last_o)
  );

  // Sequencer FSM with registered sensor, config-RAM and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= S_IDLE;
      start_r        <= 1'b0;
      clk_cnt_r      <= {CNT_W{1'b0}};
      integ_r        <= {CNT_W{1'b0}};
      frames_r       <= 16'd0;
      reset_o        <= 1'b0;
      cfg_ram_rd_o   <= 1'b0;
      cfg_ram_addr_o <= 8'd0;
      frame_cnt_o    <= 16'd0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      err_timeout_o  <= 1'b0;
    end else begin
      start_r      <= start_in;
      cfg_ram_rd_o <= 1'b0;
      done_o       <= 1'b0;
      if (abort_s) begin
        state_r   <= S_IDLE;
        reset_o   <= 1'b0;
        busy_o    <= 1'b0;
        clk_cnt_r <= {CNT_W{1'b0}};
      end else begin
        case (state_r)
          S_IDLE: begin
            if (start_s) begin
              cfg_ram_rd_o   <= 1'b1;
              cfg_ram_addr_o <= INTEG_ADDR;
              err_timeout_o  <= 1'b0;
              frame_cnt_o    <= 16'd0;
              busy_o         <= 1'b1;
              clk_cnt_r      <= {CNT_W{1'b0}};
              state_r        <= S_RD_INTEG;
            end
          end
          // Config data is taken on the edge that closes the strobe cycle.
          S_RD_INTEG: begin
            integ_r        <= cfg_ram_din[CNT_W-1:0];
            cfg_ram_rd_o   <= 1'b1;
            cfg_ram_addr_o <= FRAMES_ADDR;
            state_r        <= S_RD_FRAMES;
          end
          S_RD_FRAMES: begin
            frames_r  <= cfg_ram_din[15:0];
            reset_o   <= 1'b1;
            clk_cnt_r <= {CNT_W{1'b0}};
            state_r   <= S_INTEG;
          end
          S_INTEG: begin
            if (clk_cnt_r == integ_r) begin
              clk_cnt_r <= {CNT_W{1'b0}};
              reset_o   <= 1'b0;
              state_r   <= S_WAIT_SP;
            end else begin
              clk_cnt_r <= clk_cnt_r + CNT_ONE;
            end
          end
          S_WAIT_SP: begin
            if (ad_sp) begin
              clk_cnt_r <= {CNT_W{1'b0}};
              state_r   <= S_DATA;
            end else if (clk_cnt_r == SP_LAST) begin
              err_timeout_o <= 1'b1;
              done_o        <= 1'b1;
              state_r       <= S_DONE;
            end else begin
              clk_cnt_r <= clk_cnt_r + CNT_ONE;
            end
          end
          S_DATA: begin
            if (line_last_s) begin
              clk_cnt_r <= {CNT_W{1'b0}};
              state_r   <= S_BLANK;
            end
          end
          S_BLANK: begin
            if (clk_cnt_r == BLANK_LAST) begin
              clk_cnt_r   <= {CNT_W{1'b0}};
              frame_cnt_o <= frame_cnt_o + 16'd1;
              if (more_s) begin
                reset_o <= 1'b1;
                state_r <= S_INTEG;
              end else begin
                done_o  <= 1'b1;
                state_r <= S_DONE;
              end
            end else begin
              clk_cnt_r <= clk_cnt_r + CNT_ONE;
            end
          end
          S_DONE: begin
            busy_o  <= 1'b0;
            state_r <= S_IDLE;
          end
          default: begin
            state_r   <= S_IDLE;
            reset_o   <= 1'b0;
            busy_o    <= 1'b0;
            clk_cnt_r <= {CNT_W{1'b0}};
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lsensor_ctrl.sv
// Scoreboard bench for lsensor_ctrl: directed runs push expected pixel beats
// and done events; a negedge monitor pops and compares them.
module tb_lsensor_ctrl;

  localparam int PIX_NUM   = 512;
  localparam int ADC_W     = 12;
  localparam int BLANK_CYC = 24;

  typedef struct packed {
    logic        last;
    logic [8:0]  idx;
    logic [11:0] data;
  } pix_exp_t;

  typedef struct packed {
    logic        err;
    logic [15:0] frames;
  } done_exp_t;

  logic             clk = 1'b0;
  logic             rst_n, sensor_clk_o, reset_o, ad_sp, start_in, soft_reset_in;
  logic [ADC_W-1:0] adc_data;
  logic             cfg_ram_rd_o;
  logic [7:0]       cfg_ram_addr_o;
  logic [31:0]      cfg_ram_din;
  logic             pix_valid_o, pix_last_o, busy_o, done_o, err_timeout_o;
  logic [ADC_W-1:0] pix_data_o;
  logic [8:0]       pix_idx_o;
  logic [15:0]      frame_cnt_o;

  logic [31:0] cfg_integ, cfg_frames;
  int checks = 0, failures = 0;
  int abort_at = -1, adsp_glitch_at = -1, start_glitch_at = -1;
  pix_exp_t  pix_q[$];
  done_exp_t done_q[$];
  pix_exp_t  mon_pe;
  done_exp_t mon_de;

  always #5 clk = ~clk;

  lsensor_ctrl #(.PIX_NUM(PIX_NUM), .ADC_W(ADC_W), .BLANK_CYC(BLANK_CYC), .SP_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .sensor_clk_o(sensor_clk_o), .reset_o(reset_o),
    .ad_sp(ad_sp), .adc_data(adc_data), .start_in(start_in), .soft_reset_in(soft_reset_in),
    .cfg_ram_rd_o(cfg_ram_rd_o), .cfg_ram_addr_o(cfg_ram_addr_o), .cfg_ram_din(cfg_ram_din),
    .pix_valid_o(pix_valid_o), .pix_data_o(pix_data_o), .pix_idx_o(pix_idx_o),
    .pix_last_o(pix_last_o), .frame_cnt_o(frame_cnt_o), .busy_o(busy_o),
    .done_o(done_o), .err_timeout_o(err_timeout_o)
  );

  // Config RAM: word is presented while its read strobe is high, junk otherwise.
  always_comb begin
    cfg_ram_din = 32'hDEAD_BEEF;
    if (cfg_ram_rd_o && cfg_ram_addr_o == 8'd1) cfg_ram_din = cfg_integ;
    else if (cfg_ram_rd_o && cfg_ram_addr_o == 8'd2) cfg_ram_din = cfg_frames;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] pix_val(input int line, input int i);
    int t;
    t = line * 397 + i * 7 + 11;
    return t[11:0];
  endfunction

  // Monitor: every presented beat / done pulse must match the queue head.
  always @(negedge clk) begin
    if (pix_valid_o) begin
      if (pix_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pix_unexpected actual=beat idx %0d expected=no beat at %0t", pix_idx_o, $time);
      end else begin
        mon_pe = pix_q.pop_front();
        check("pix_beat", {pix_last_o, pix_idx_o, pix_data_o}, mon_pe);
      end
    end
    if (done_o) begin
      if (done_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL done_unexpected actual=done pulse expected=none at %0t", $time);
      end else begin
        mon_de = done_q.pop_front();
        check("done_status", {err_timeout_o, frame_cnt_o}, mon_de);
      end
    end
  end

  task automatic pulse_start();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  task automatic wait_integ(input int wait_exp, input int integ_cyc, input int frame_exp);
    int n;
    n = 0;
    while (reset_o !== 1'b1 && n < 3000) begin tick(); n++; end
    check("integ_entry_cycles", n, wait_exp);
    check("frame_cnt_at_integ", frame_cnt_o, frame_exp);
    n = 0;
    while (reset_o === 1'b1 && n < 3000) begin tick(); n++; end
    check("integ_len", n, integ_cyc);
  endtask

  task automatic run_line(input int line, input int wait_exp, input int integ_cyc,
                          input int d, input int frame_exp);
    pix_exp_t pe;
    wait_integ(wait_exp, integ_cyc, frame_exp);
    repeat (d) tick();
    ad_sp = 1'b1;
    tick();
    ad_sp = 1'b0;
    for (int i = 0; i < PIX_NUM; i++) begin
      adc_data = pix_val(line, i);
      ad_sp = (i == adsp_glitch_at);
      if (start_glitch_at >= 0 && i == start_glitch_at) start_in = 1'b1;
      if (start_glitch_at >= 0 && i == start_glitch_at + 1) begin
        start_in = 1'b0;
        check("start_ignored_rd", cfg_ram_rd_o, 0);
      end
      if (i == abort_at) begin
        soft_reset_in = 1'b1;
        tick();
        soft_reset_in = 1'b0;
        ad_sp = 1'b0;
        check("abort_idle", {busy_o, reset_o, pix_valid_o, done_o}, 0);
        return;
      end
      pe.last = (i == PIX_NUM - 1);
      pe.idx  = 9'(i);
      pe.data = pix_val(line, i);
      pix_q.push_back(pe);
      tick();
    end
    ad_sp = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_o === 1'b1 && n < 2000) begin tick(); n++; end
    check("run_end_busy", busy_o, 0);
  endtask

  task automatic check_queues();
    tick();
    check("pix_q_empty", pix_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; ad_sp = 1'b0; start_in = 1'b0; soft_reset_in = 1'b0;
    adc_data = 12'd0; cfg_integ = 32'd0; cfg_frames = 32'd0;
    repeat (3) tick();
    check("reset_outputs", {reset_o, busy_o, pix_valid_o, pix_last_o, pix_data_o, pix_idx_o,
          cfg_ram_rd_o, cfg_ram_addr_o, frame_cnt_o, done_o, err_timeout_o}, 0);
    @(negedge clk);
    check("sensor_clk_inv", sensor_clk_o, 1);
    rst_n = 1'b1;
    tick();

    // Single frame, start held high through the whole run; ad_sp glitch in DATA.
    cfg_integ = 32'd10; cfg_frames = 32'hABCD_0001; adsp_glitch_at = 300;
    done_q.push_back('{err: 1'b0, frames: 16'd1});
    start_in = 1'b1;
    tick();
    run_line(0, 2, 11, 5, 0);
    wait_idle();
    check("single_frame_cnt", frame_cnt_o, 1);
    repeat (5) tick();
    check("held_start_one_run", busy_o, 0);
    start_in = 1'b0; adsp_glitch_at = -1;
    check_queues();

    // Three frames, integ 0, start edge during DATA ignored.
    cfg_integ = 32'd0; cfg_frames = 32'd3; start_glitch_at = 100;
    done_q.push_back('{err: 1'b0, frames: 16'd3});
    pulse_start();
    run_line(1, 2, 1, 2, 0);
    start_glitch_at = -1;
    run_line(2, BLANK_CYC, 1, 2, 1);
    run_line(3, BLANK_CYC, 1, 2, 2);
    wait_idle();
    check("multi_frame_cnt", frame_cnt_o, 3);
    check_queues();

    // Continuous: five full lines, then soft reset at idx 200 of the sixth.
    cfg_integ = 32'd1; cfg_frames = 32'd0;
    pulse_start();
    for (int k = 0; k < 5; k++) run_line(10 + k, (k == 0) ? 2 : BLANK_CYC, 2, 3, k);
    abort_at = 200;
    run_line(15, BLANK_CYC, 2, 3, 5);
    abort_at = -1;
    repeat (3) tick();
    check("cont_stays_idle", busy_o, 0);
    check("cont_frame_cnt", frame_cnt_o, 5);
    check_queues();

    // WAIT_SP timeout with no ad_sp.
    cfg_integ = 32'd2; cfg_frames = 32'd1;
    done_q.push_back('{err: 1'b1, frames: 16'd0});
    pulse_start();
    wait_integ(2, 3, 0);
    repeat (15) tick();
    check("timeout_not_yet", {busy_o, err_timeout_o}, 2'b10);
    tick();
    check("timeout_err_set", err_timeout_o, 1);
    wait_idle();
    check("timeout_err_sticky", err_timeout_o, 1);
    check_queues();

    // Next start clears the error; ad_sp on the final timeout cycle wins.
    done_q.push_back('{err: 1'b0, frames: 16'd1});
    pulse_start();
    check("start_clears_err", err_timeout_o, 0);
    run_line(20, 2, 3, 15, 0);
    wait_idle();
    check("adsp_beats_timeout", err_timeout_o, 0);
    check_queues();

    // rst_n asserted during INTEG, then a fresh run.
    cfg_integ = 32'd10; cfg_frames = 32'd1;
    pulse_start();
    for (int n = 0; n < 20 && reset_o !== 1'b1; n++) tick();
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    check("midrun_reset_outputs", {reset_o, busy_o, pix_valid_o, pix_last_o, pix_data_o, pix_idx_o,
          cfg_ram_rd_o, cfg_ram_addr_o, frame_cnt_o, done_o, err_timeout_o}, 0);
    rst_n = 1'b1;
    tick();
    check("after_reset_idle", busy_o, 0);
    done_q.push_back('{err: 1'b0, frames: 16'd1});
    pulse_start();
    run_line(30, 2, 11, 4, 0);
    wait_idle();
    check_queues();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
